// File: rtl/ctrl_frame_conditioner_if.sv
// Frame bus between the receiver/game logic and the frame conditioner.
// new_frame and out_valid are one-cycle strobes with no back-pressure: data is valid only in the strobe cycle.
interface ctrl_frame_conditioner_if;
  logic signed [15:0] ax1, ay1, az1, ax2, ay2, az2;
  logic        [11:0] jx, jy;
  logic               btn;
  logic               new_frame;

  logic signed [15:0] fax1, fay1, faz1, fax2, fay2, faz2;
  logic signed [11:0] joy_x, joy_y;
  logic               btn_level;
  logic               btn_press;
  logic               out_valid;
  logic               link_ok;
  logic        [15:0] frame_cnt;
  logic        [7:0]  drop_cnt;

  modport slave (
    input  ax1, ay1, az1, ax2, ay2, az2, jx, jy, btn, new_frame,
    output fax1, fay1, faz1, fax2, fay2, faz2, joy_x, joy_y,
           btn_level, btn_press, out_valid, link_ok, frame_cnt, drop_cnt
  );

  modport master (
    output ax1, ay1, az1, ax2, ay2, az2, jx, jy, btn, new_frame,
    input  fax1, fay1, faz1, fax2, fay2, faz2, joy_x, joy_y,
           btn_level, btn_press, out_valid, link_ok, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/ctrl_frame_conditioner.sv
// Captures a controller frame, smooths accelerations, conditions joystick and button,
// and publishes a registered frame eight cycles later; also tracks link loss.
module ctrl_frame_conditioner #(
  parameter int JOY_CENTER   = 2048,
  parameter int JOY_DEAD     = 64,
  parameter int SMOOTH_SHIFT = 2,
  parameter int BTN_FRAMES   = 3,
  parameter int TIMEOUT_CYC  = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ctrl_frame_conditioner_if.slave bus,
  output logic [1:0]              state_dbg
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILT = 2'd1;
  localparam logic [1:0] S_JOY  = 2'd2;
  localparam logic [1:0] S_PUB  = 2'd3;

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
  localparam logic signed [13:0] JOY_C   = 14'(JOY_CENTER);
  localparam logic signed [13:0] JOY_D   = 14'(JOY_DEAD);
  localparam logic signed [13:0] JOY_LIM = 14'sd2047;
  localparam logic [3:0]      BTN_N   = 4'(BTN_FRAMES);

  logic [1:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic signed [15:0] cap_a_q [6];
  logic signed [15:0] cap_a_d [6];
  logic [11:0]        cap_jx_q, cap_jx_d, cap_jy_q, cap_jy_d;
  logic               cap_btn_q, cap_btn_d;
  logic signed [15:0] acc_q [6];
  logic signed [15:0] acc_d [6];
  logic               prime_q, prime_d;
  logic [3:0]         agree_q, agree_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic signed [15:0] fa_q [6];
  logic signed [15:0] fa_d [6];
  logic [11:0]        joy_x_q, joy_x_d, joy_y_q, joy_y_d;
  logic               btn_level_q, btn_level_d;
  logic               btn_press_q, btn_press_d;
  logic               out_valid_q, out_valid_d;
  logic               link_ok_q, link_ok_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic               accept;
  logic signed [15:0] ema_sample, ema_cur, ema_next;
  logic signed [16:0] ema_diff, ema_step;
  logic [3:0]         agree_inc;
  logic               lvl_new;

  // Centre, dead-zone and clamp one joystick axis.
  function automatic logic [11:0] joy_cond(input logic [11:0] raw);
    logic signed [13:0] d;
    logic signed [13:0] r;
    d = $signed({2'b00, raw}) - JOY_C;
    if (d <= JOY_D && d >= -JOY_D) r = '0;
    else if (d > 14'sd0)           r = d - JOY_D;
    else                           r = d + JOY_D;
    if (r > JOY_LIM)       r = JOY_LIM;
    else if (r < -JOY_LIM) r = -JOY_LIM;
    return r[11:0];
  endfunction

  // Shared EMA datapath; the shifted step never overshoots the sample, so no saturation.
  always_comb begin
    ema_sample = cap_a_q[idx_q];
    ema_cur    = acc_q[idx_q];
    ema_diff   = {ema_sample[15], ema_sample} - {ema_cur[15], ema_cur};
    ema_step   = ema_diff >>> SMOOTH_SHIFT;
    ema_next   = ema_cur + ema_step[15:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cap_a_d     = cap_a_q;
    cap_jx_d    = cap_jx_q;
    cap_jy_d    = cap_jy_q;
    cap_btn_d   = cap_btn_q;
    acc_d       = acc_q;
    prime_d     = prime_q;
    agree_d     = agree_q;
    wd_d        = wd_q;
    fa_d        = fa_q;
    joy_x_d     = joy_x_q;
    joy_y_d     = joy_y_q;
    btn_level_d = btn_level_q;
    btn_press_d = 1'b0;
    out_valid_d = 1'b0;
    link_ok_d   = link_ok_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    agree_inc   = agree_q + 4'd1;
    lvl_new     = btn_level_q;
    accept      = (state_q == S_IDLE) && bus.new_frame;

    case (state_q)
      S_IDLE: begin
        if (bus.new_frame) begin
          cap_a_d[0] = bus.ax1;
          cap_a_d[1] = bus.ay1;
          cap_a_d[2] = bus.az1;
          cap_a_d[3] = bus.ax2;
          cap_a_d[4] = bus.ay2;
          cap_a_d[5] = bus.az2;
          cap_jx_d   = bus.jx;
          cap_jy_d   = bus.jy;
          cap_btn_d  = bus.btn;
          idx_d      = 3'd0;
          state_d    = S_FILT;
        end
      end
      S_FILT: begin
        acc_d[idx_q] = prime_q ? ema_sample : ema_next;
        if (idx_q == 3'd5) state_d = S_JOY;
        else               idx_d   = idx_q + 3'd1;
      end
      S_JOY: begin
        if (cap_btn_q != btn_level_q) begin
          if (agree_inc == BTN_N) begin
            lvl_new = ~btn_level_q;
            agree_d = 4'd0;
          end else begin
            agree_d = agree_inc;
          end
        end else begin
          agree_d = 4'd0;
        end
        // Outputs load on the edge entering PUB so out_valid and data appear together.
        fa_d        = acc_q;
        joy_x_d     = joy_cond(cap_jx_q);
        joy_y_d     = joy_cond(cap_jy_q);
        btn_level_d = lvl_new;
        btn_press_d = lvl_new & ~btn_level_q;
        out_valid_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        link_ok_d   = 1'b1;
        prime_d     = 1'b0;
        state_d     = S_PUB;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.new_frame && state_q != S_IDLE && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;

    if (accept)              wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
    if (wd_d == WD_MAX) begin
      link_ok_d = 1'b0;
      prime_d   = 1'b1;
      agree_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      for (int i = 0; i < 6; i++) begin
        cap_a_q[i] <= '0;
        acc_q[i]   <= '0;
        fa_q[i]    <= '0;
      end
      cap_jx_q    <= '0;
      cap_jy_q    <= '0;
      cap_btn_q   <= 1'b0;
      prime_q     <= 1'b1;
      agree_q     <= 4'd0;
      wd_q        <= '0;
      joy_x_q     <= '0;
      joy_y_q     <= '0;
      btn_level_q <= 1'b0;
      btn_press_q <= 1'b0;
      out_valid_q <= 1'b0;
      link_ok_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cap_a_q     <= cap_a_d;
      acc_q       <= acc_d;
      fa_q        <= fa_d;
      cap_jx_q    <= cap_jx_d;
      cap_jy_q    <= cap_jy_d;
      cap_btn_q   <= cap_btn_d;
      prime_q     <= prime_d;
      agree_q     <= agree_d;
      wd_q        <= wd_d;
      joy_x_q     <= joy_x_d;
      joy_y_q     <= joy_y_d;
      btn_level_q <= btn_level_d;
      btn_press_q <= btn_press_d;
      out_valid_q <= out_valid_d;
      link_ok_q   <= link_ok_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.fax1      = fa_q[0];
  assign bus.fay1      = fa_q[1];
  assign bus.faz1      = fa_q[2];
  assign bus.fax2      = fa_q[3];
  assign bus.fay2      = fa_q[4];
  assign bus.faz2      = fa_q[5];
  assign bus.joy_x     = joy_x_q;
  assign bus.joy_y     = joy_y_q;
  assign bus.btn_level = btn_level_q;
  assign bus.btn_press = btn_press_q;
  assign bus.out_valid = out_valid_q;
  assign bus.link_ok   = link_ok_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_ctrl_frame_conditioner.sv
// Bench for ctrl_frame_conditioner: directed plan cases plus random frames
// scored against a frame-level reference model.
module tb_ctrl_frame_conditioner;
  localparam int TMO   = 50;
  localparam int SH    = 2;
  localparam int BTN_N = 3;
  localparam int EW    = 138;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;

  ctrl_frame_conditioner_if bus();

  ctrl_frame_conditioner #(
    .JOY_CENTER(2048), .JOY_DEAD(64), .SMOOTH_SHIFT(SH),
    .BTN_FRAMES(BTN_N), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / cycle index
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input integer got, input integer exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // reference model state
  int acc_m [6];
  int lvl_m, run_m, fcnt_m, drop_m, last_acc, last_press;
  bit prime_m, link_m, mon_en;
  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  int fa_in [6];
  int jxv [5] = '{2048, 2112, 2113, 0, 4095};
  int jxe [5] = '{0, 0, 1, -1984, 1983};
  int jyv [5] = '{2048, 1984, 1983, 4095, 0};
  int jye [5] = '{0, 0, -1, 1983, -1984};
  int bseq[6] = '{1, 1, 0, 1, 1, 1};
  int lvle[6] = '{0, 0, 0, 0, 0, 1};

  function automatic int ema_ref(int acc, int x);
    int d = x - acc;
    int step;
    if (d >= 0) step = d / (1 << SH);
    else        step = -((-d + (1 << SH) - 1) / (1 << SH));
    return acc + step;
  endfunction

  function automatic int joy_ref(int raw);
    int d = raw - 2048;
    int mag;
    mag = (d < 0 ? -d : d) - 64;
    if (mag <= 0) return 0;
    if (mag > 2047) mag = 2047;
    return (d < 0) ? -mag : mag;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) acc_m[i] = 0;
    lvl_m = 0; run_m = 0; fcnt_m = 0; drop_m = 0;
    last_acc = -1; prime_m = 1; link_m = 0;
    exp_q.delete(); due_q.delete();
  endtask

  task automatic scramble();
    bus.ax1 = 16'($urandom); bus.ay1 = 16'($urandom); bus.az1 = 16'($urandom);
    bus.ax2 = 16'($urandom); bus.ay2 = 16'($urandom); bus.az2 = 16'($urandom);
    bus.jx  = 12'($urandom); bus.jy  = 12'($urandom);
    bus.btn = 1'($urandom_range(0, 1));
  endtask

  // driver: frame in the current cycle, optional overrun pulse / reset at offset k
  task automatic run_frame(input int a[6], input int jx, input int jy, input bit btn,
                           input int gap, input int ovr_k, input int rst_k);
    bit timed_out;
    int prev;
    logic [EW-1:0] e;
    timed_out = (last_acc >= 0) && (cyc - last_acc > TMO);
    if (timed_out) begin
      run_m  = 0;
      link_m = 0;
    end
    for (int i = 0; i < 6; i++)
      acc_m[i] = (prime_m || timed_out) ? a[i] : ema_ref(acc_m[i], a[i]);
    prev = lvl_m;
    if (int'(btn) != lvl_m) begin
      run_m++;
      if (run_m == BTN_N) begin lvl_m = int'(btn); run_m = 0; end
    end else run_m = 0;
    fcnt_m   = (fcnt_m + 1) % 65536;
    prime_m  = 0;
    last_acc = cyc;
    e = '0;
    e[15:0]  = 16'(fcnt_m);
    e[16]    = (lvl_m == 1 && prev == 0);
    e[17]    = (lvl_m != 0);
    e[29:18] = 12'(joy_ref(jy));
    e[41:30] = 12'(joy_ref(jx));
    for (int i = 0; i < 6; i++) e[42 + 16*i +: 16] = 16'(acc_m[i]);
    exp_q.push_back(e);
    due_q.push_back(cyc + 8);

    bus.ax1 = 16'(a[0]); bus.ay1 = 16'(a[1]); bus.az1 = 16'(a[2]);
    bus.ax2 = 16'(a[3]); bus.ay2 = 16'(a[4]); bus.az2 = 16'(a[5]);
    bus.jx = 12'(jx); bus.jy = 12'(jy); bus.btn = btn;
    bus.new_frame = 1'b1;
    @(posedge clk); #1;
    bus.new_frame = 1'b0;
    scramble();
    for (int i = 1; i < gap; i++) begin
      if (i == rst_k) begin
        rst_n = 1'b0;
        if (i == ovr_k) bus.new_frame = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.new_frame = 1'b0;
        model_reset();
      end else begin
        if (i == ovr_k) begin scramble(); bus.new_frame = 1'b1; end
        @(posedge clk); #1;
        bus.new_frame = 1'b0;
        if (i == ovr_k) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
      end
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  logic [EW-1:0]      mon_e;
  int                 mon_due;
  logic signed [15:0] fa_dut [6];

  always @(negedge clk) begin
    if (mon_en) begin
      if (last_acc >= 0 && cyc - last_acc == TMO + 1) link_m = 0;
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_due = due_q.pop_front();
          fa_dut  = '{bus.fax1, bus.fay1, bus.faz1, bus.fax2, bus.fay2, bus.faz2};
          check("valid_cycle", cyc, mon_due);
          for (int i = 0; i < 6; i++)
            check($sformatf("fa%0d", i), fa_dut[i], $signed(mon_e[42 + 16*i +: 16]));
          check("joy_x", bus.joy_x, $signed(mon_e[41:30]));
          check("joy_y", bus.joy_y, $signed(mon_e[29:18]));
          check("btn_level", bus.btn_level, mon_e[17]);
          check("btn_press", bus.btn_press, mon_e[16]);
          check("frame_cnt", bus.frame_cnt, mon_e[15:0]);
          check("drop_cnt", bus.drop_cnt, drop_m);
          link_m     = 1;
          last_press = int'(bus.btn_press);
        end
      end else begin
        if (due_q.size() > 0 && cyc >= due_q[0]) begin
          check("valid_missing", 0, 1);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        check("press_idle", bus.btn_press, 0);
      end
      check("link_ok", bus.link_ok, link_m);
    end
  end

  initial begin
    int r;
    int gap;
    int ovr;
    bit b;
    bus.new_frame = 1'b0;
    scramble();
    model_reset();
    last_press = 0;
    mon_en = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check("rst_fax1", bus.fax1, 0);
    check("rst_faz2", bus.faz2, 0);
    check("rst_joy_x", bus.joy_x, 0);
    check("rst_joy_y", bus.joy_y, 0);
    check("rst_btn_level", bus.btn_level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clk); #1;

    // prime then smoothing
    fa_in = '{1000, 0, 0, 0, 0, 0};
    run_frame(fa_in, 2048, 2048, 1'b0, 12, 0, 0);
    check("smooth_prime", bus.fax1, 1000);
    fa_in[0] = 0;
    run_frame(fa_in, 2048, 2048, 1'b0, 12, 0, 0);
    check("smooth_1", bus.fax1, 750);
    run_frame(fa_in, 2048, 2048, 1'b0, 12, 0, 0);
    check("smooth_2", bus.fax1, 562);

    // joystick centring / dead zone
    for (int k = 0; k < 5; k++) begin
      run_frame(fa_in, jxv[k], jyv[k], 1'b0, 10, 0, 0);
      check($sformatf("joy_x_dir%0d", k), bus.joy_x, jxe[k]);
      check($sformatf("joy_y_dir%0d", k), bus.joy_y, jye[k]);
    end

    // button debounce
    for (int k = 0; k < 6; k++) begin
      run_frame(fa_in, 2048, 2048, bseq[k][0], 10, 0, 0);
      check($sformatf("btn_level_dir%0d", k), bus.btn_level, lvle[k]);
      check($sformatf("btn_press_dir%0d", k), last_press, lvle[k]);
    end

    // reset mid-FILT, coinciding with a new_frame pulse
    fa_in = '{5000, 0, 0, 0, 0, 0};
    run_frame(fa_in, 2048, 2048, 1'b1, 12, 4, 4);
    check("mrst_frame_cnt", bus.frame_cnt, 0);
    check("mrst_drop_cnt", bus.drop_cnt, 0);
    check("mrst_fax1", bus.fax1, 0);
    check("mrst_btn_level", bus.btn_level, 0);
    check("mrst_link", bus.link_ok, 0);
    fa_in[0] = 777;
    run_frame(fa_in, 2048, 2048, 1'b0, 12, 0, 0);
    check("mrst_reprime", bus.fax1, 777);

    // overrun: pulse at T+3 dropped, T+9 accepted, pulse in PUB dropped
    run_frame(fa_in, 2048, 2048, 1'b0, 9, 3, 0);
    check("ovr_drop1", bus.drop_cnt, 1);
    check("ovr_fcnt1", bus.frame_cnt, 2);
    run_frame(fa_in, 2048, 2048, 1'b0, 9, 8, 0);
    check("ovr_drop2", bus.drop_cnt, 2);
    check("ovr_fcnt2", bus.frame_cnt, 3);

    // watchdog expiry and reprime
    fa_in[0] = 1234;
    run_frame(fa_in, 2048, 2048, 1'b0, 60, 0, 0);
    check("wd_link_low", bus.link_ok, 0);
    fa_in[0] = -300;
    run_frame(fa_in, 2048, 2048, 1'b0, 12, 0, 0);
    check("wd_reprime", bus.fax1, -300);
    check("wd_link_high", bus.link_ok, 1);

    // random frames
    b = 1'b0;
    repeat (150) begin
      for (int i = 0; i < 6; i++) fa_in[i] = int'($signed(16'($urandom)));
      if ($urandom_range(0, 3) == 0) b = ~b;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0:       gap = 50;
          1:       gap = 51;
          default: gap = int'($urandom_range(55, 70));
        endcase
      end else begin
        gap = int'($urandom_range(9, 20));
      end
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_frame(fa_in,
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(1978, 2118)) : int'($urandom_range(0, 4095)),
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(1978, 2118)) : int'($urandom_range(0, 4095)),
                b, gap, ovr, 0);
    end

    repeat (12) @(posedge clk);
    #1;
    check("exp_drained", exp_q.size(), 0);
    check("final_drop_cnt", bus.drop_cnt, drop_m);
    check("final_frame_cnt", bus.frame_cnt, fcnt_m);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
